// File: rtl/isqrt_ip.sv
// isqrt_ip: FIFO-buffered 32-bit unsigned integer square root, one result bit per cycle; ISQRT_REM_EN exports the remainder
module isqrt_ip #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic [31:0]      IPdata_in,
  output logic [31:0]      IPdata_out,
  output logic             ready,
  output logic             fifo_full,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic [31:0] op;
  logic [17:0] rem, rem_s, trial, rem_n;
  logic [15:0] root, root_n, hi;
  logic [3:0] iter;
  logic pop, push, ge;
  assign pop = state == IDLE && count != '0;
  assign push = write && (count != FULL || pop);
  always_comb begin
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    rem_s = {rem[15:0], op[31:30]};
    trial = {root, 2'b01};
    ge = rem_s >= trial;
    rem_n = ge ? rem_s - trial : rem_s;
    root_n = {root[14:0], ge};
  end
`ifdef ISQRT_REM_EN
  assign hi = rem_n[17:16] != 2'b00 ? 16'hFFFF : rem_n[15:0];
`else
  assign hi = '0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= IPdata_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      fifo_full <= 1'b0;
      drop_cnt <= '0;
      op <= '0;
      rem <= '0;
      root <= '0;
      iter <= '0;
      ready <= 1'b0;
      IPdata_out <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_n;
      fifo_full <= count_n == FULL;
      if (write && !push && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (state == IDLE) begin
        if (pop) begin
          op <= mem[rd_ptr];
          rem <= '0;
          root <= '0;
          iter <= '0;
          ready <= 1'b0;
          state <= CALC;
        end
      end else begin
        rem <= rem_n;
        root <= root_n;
        op <= {op[29:0], 2'b00};
        iter <= iter + 4'd1;
        if (iter == 4'd15) begin
          IPdata_out <= {hi, root_n};
          ready <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_isqrt_ip.sv
// tb_isqrt_ip: directed and random checks of isqrt_ip against an arithmetic square-root model
module tb_isqrt_ip;
  logic clk = 0, rst = 1, write = 0;
  logic [31:0] IPdata_in = '0, IPdata_out;
  logic ready, fifo_full;
  logic [7:0] drop_cnt;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_drop = 0;
  isqrt_ip dut (.clk(clk), .rst(rst), .write(write), .IPdata_in(IPdata_in),
    .IPdata_out(IPdata_out), .ready(ready), .fifo_full(fifo_full), .drop_cnt(drop_cnt));
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [31:0] x);
    longint unsigned lo = 0, hi = 65535, mid, r, rm;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid; else hi = mid - 1;
    end
    r = lo;
    rm = longint'(x) - r * r;
`ifdef ISQRT_REM_EN
    return {rm > 65535 ? 16'hFFFF : rm[15:0], r[15:0]};
`else
    return {16'h0, r[15:0]};
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [31:0] x, input string tag);
    IPdata_in = x;
    write = 1;
    @(negedge clk);
    write = 0;
    repeat (16) @(negedge clk);
    chk({tag, "_not_yet"}, 32'(ready), 32'd0);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk(tag, IPdata_out, model(x));
  endtask
  initial begin
    logic [31:0] vals [6];
    vals = '{4, 9, 16, 25, 36, 49};
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_out", IPdata_out, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    do_op(32'h0, "zero");
    chk("zero_abs", IPdata_out, 32'h0);
    do_op(32'h000F4240, "million");
    chk("million_root", 32'(IPdata_out[15:0]), 32'h3E8);
    do_op(32'h11, "seventeen");
    do_op(32'hFFFFFFFF, "allones");
    chk("allones_root", 32'(IPdata_out[15:0]), 32'hFFFF);
    for (int i = 0; i < 6; i++) begin
      IPdata_in = vals[i];
      write = 1;
      @(negedge clk);
      if (i == 3) chk("full_before", 32'(fifo_full), 32'd0);
      if (i == 4) chk("full_after", 32'(fifo_full), 32'd1);
    end
    write = 0;
    exp_drop++;
    chk("drop_one", 32'(drop_cnt), 32'(exp_drop));
    repeat (12) @(negedge clk);
    chk("burst0_ready", 32'(ready), 32'd1);
    chk("burst0", IPdata_out, model(vals[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (16) @(negedge clk);
      chk("burst_gap", 32'(ready), 32'd0);
      @(negedge clk);
      chk("burst_ready", 32'(ready), 32'd1);
      chk("burst", IPdata_out, model(vals[i]));
    end
    repeat (3) @(negedge clk);
    chk("burst_idle_ready", 32'(ready), 32'd1);
    IPdata_in = 32'h400;
    write = 1;
    @(negedge clk);
    write = 0;
    repeat (8) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_drop = 0;
    chk("abort_out", IPdata_out, 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_full", 32'(fifo_full), 32'd0);
    chk("abort_drop", 32'(drop_cnt), 32'(exp_drop));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) chk("abort_no_result", 32'(ready), 32'd0);
    end
    chk("abort_quiet", 32'(ready), 32'd0);
    do_op(32'h400, "after_abort");
    chk("after_abort_abs", IPdata_out, 32'h20);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x;
      x = $urandom;
      if (i % 3 == 1) x = x >> $urandom_range(31, 1);
      do_op(x, "random");
    end
    chk("final_drop", 32'(drop_cnt), 32'(exp_drop));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/isqrt_ip.md
Name: isqrt_ip

Overview:
Processing IP that sits directly downstream of the bus wrapper. It consumes the wrapper's operand word (`IPdata_in` qualified by `write`) and returns the result word (`IPdata_out` qualified by `ready`).
- Operands are buffered in a small input FIFO.
- Each operand gets an unsigned 32-bit integer square root, computed iteratively at one result bit per cycle.
- Overflow of the input FIFO is counted for debug.

Parameters:
- `DEPTH`, default 4: input FIFO entries; power of 2, at least 2.
- `CNT_W`, default 8: width of the saturating drop counter.

Ports:
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `write`  input  1  push strobe; one operand accepted per cycle it is high
- `IPdata_in`  input  32  unsigned operand, sampled when `write`=1
- `IPdata_out`  output  32  result word; valid while `ready`=1
- `ready`  output  1  result valid
- `fifo_full`  output  1  FIFO holds `DEPTH` entries
- `drop_cnt`  output  `CNT_W`  saturating count of rejected pushes

Behaviour:
- Reset (synchronous, `rst`=1 at a rising edge) clears everything:
  - `IPdata_out`=0, `ready`=0, `fifo_full`=0, `drop_cnt`=0.
  - FIFO emptied (pointers and count to 0), FSM to IDLE, datapath registers to 0.
  - Reset mid-computation aborts the operation; no result is produced.
- FIFO:
  - Circular buffer with a count of log2(`DEPTH`)+1 bits; pointers wrap modulo `DEPTH`.
  - Push accepted if `write`=1 and (count<`DEPTH` or a pop occurs the same cycle).
  - If `write`=1 while full with no pop, the word is discarded and `drop_cnt` increments, saturating at all-ones.
  - Simultaneous push and pop leaves count unchanged.
  - `fifo_full` = (count==`DEPTH`), registered alongside the count.
- FSM states: IDLE, CALC.
  - IDLE, FIFO non-empty: pop the head into `op`, clear `rem` (18 b) and `root` (16 b), set `iter`=0, clear `ready`, go to CALC.
  - IDLE, FIFO empty: hold; `ready` and `IPdata_out` unchanged.
  - CALC, one bit per cycle:
    - `rem_s` = {`rem`[15:0], `op`[31:30]}
    - `trial` = {`root`, 2'b01}, zero-extended to 18 b
    - if `rem_s` >= `trial`: `rem` = `rem_s`-`trial`, `root` = {`root`[14:0], 1}
    - else: `rem` = `rem_s`, `root` = {`root`[14:0], 0}
    - `op` = `op`<<2; `iter`++
  - On the edge completing iteration 15:
    - `IPdata_out`[15:0] = final root; upper bits per the optional feature.
    - `ready`=1, go to IDLE.
  - Extra writes during CALC only fill the FIFO.
- Latency:
  - Write sampled at edge N with FIFO empty and FSM IDLE: pop at N+1, `ready`=1 after N+17, i.e. 17 cycles write-to-result.
  - Back-to-back operands: one result per 17 cycles.
  - `ready` stays high at least one cycle. It drops on the pop edge of the next operand.
  - `IPdata_out` holds its last value until the next completion.
- Arithmetic:
  - Unsigned only.
  - Final remainder fits in 17 bits (max 0x1FFFE).
  - Root max 0xFFFF.

Optional Feature:
Macro `ISQRT_REM_EN`.
- Defined: on completion `IPdata_out`[31:16] = final remainder, saturated to 16'hFFFF if it exceeds 16 bits.
- Undefined: `IPdata_out`[31:16] = 0. The remainder is not exported, and the saturation logic is not built.

Test Plan:
- Reset, then write 0x00000000 at edge N -> `ready`=1 after N+17; `IPdata_out`=0x00000000 in both builds.
- Write 0x000F4240 (1000000) -> `IPdata_out`[15:0]=0x03E8; [31:16]=0 in both builds.
- Write 0x00000011 (17) -> [15:0]=0x0004; with `ISQRT_REM_EN` [31:16]=0x0001, otherwise 0.
- Write 0xFFFFFFFF -> [15:0]=0xFFFF; with `ISQRT_REM_EN` [31:16]=0xFFFF (remainder 0x1FFFE saturated).
- Six consecutive writes at edges N..N+5 (values 4, 9, 16, 25, 36, 49) from idle/empty:
  - First pop at N+1.
  - `fifo_full`=1 after N+4.
  - Sixth word dropped, `drop_cnt`=1.
  - Results 2, 3, 4, 5, 6 appear 17 cycles apart.
- Write 0x00000400, assert `rst` for one cycle at the 8th CALC cycle -> no `ready` pulse; all outputs 0; FIFO empty. A following write of 0x00000400 -> result 0x0020 after 17 cycles.
